// File: rtl/synthesijer_div_multi.sv
// Iterative restoring divider, signed/unsigned per operation, 1/2/4 quotient bits per cycle.
// Optional macro SYNTHESIJER_DIV_ZERO_BYPASS_EN: divide-by-zero skips CALC and goes straight to DONE.
module synthesijer_div_multi #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             unsigned_mode,
    input  logic             nd,
    output logic             busy,
    output logic [WIDTH-1:0] quantient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             valid
);

    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dq;        // dividend bits shift out of the top, quotient bits shift in at the bottom
    logic [WIDTH:0]   pr;        // partial remainder
    logic [WIDTH-1:0] b_mag_r;
    logic [WIDTH-1:0] a_raw;
    logic             q_sign;
    logic             r_sign;
    logic             zero_r;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] dq_next;
    logic [WIDTH:0]   pr_next;
    logic [WIDTH:0]   pr_shift;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Negating the most negative value yields 2^(WIDTH-1), which is the correct unsigned magnitude.
    always_comb begin
        a_mag = (!unsigned_mode && a[WIDTH-1]) ? -a : a;
        b_mag = (!unsigned_mode && b[WIDTH-1]) ? -b : b;
    end

    // NOTE: blocking assignments here are intentional; each loop pass consumes the previous pass's result,
    // and every variable gets a default first so no latch is inferred.
    always_comb begin
        dq_next  = dq;
        pr_next  = pr;
        pr_shift = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            pr_shift = {pr_next[WIDTH-1:0], dq_next[WIDTH-1]};
            if (pr_shift >= {1'b0, b_mag_r}) begin
                pr_next = pr_shift - {1'b0, b_mag_r};
                dq_next = {dq_next[WIDTH-2:0], 1'b1};
            end else begin
                pr_next = pr_shift;
                dq_next = {dq_next[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        q_fix = q_sign ? -dq : dq;
        r_fix = r_sign ? -pr[WIDTH-1:0] : pr[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            dq          <= '0;
            pr          <= '0;
            b_mag_r     <= '0;
            a_raw       <= '0;
            q_sign      <= 1'b0;
            r_sign      <= 1'b0;
            zero_r      <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            quantient   <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (nd) begin
                        dq      <= a_mag;
                        pr      <= '0;
                        b_mag_r <= b_mag;
                        a_raw   <= a;
                        q_sign  <= !unsigned_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_sign  <= !unsigned_mode && a[WIDTH-1];
                        zero_r  <= (b == '0);
                        count   <= CW'(ITER);
                        busy    <= 1'b1;
`ifdef SYNTHESIJER_DIV_ZERO_BYPASS_EN
                        state   <= (b == '0) ? DONE : CALC;
`else
                        state   <= CALC;
`endif
                    end
                end
                CALC: begin
                    dq    <= dq_next;
                    pr    <= pr_next;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (zero_r) begin
                        quantient <= '1;
                        remainder <= a_raw;
                    end else begin
                        quantient <= q_fix;
                        remainder <= r_fix;
                    end
                    div_by_zero <= zero_r;
                    valid       <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_synthesijer_div_multi.sv
// Directed bench for synthesijer_div_multi: a 1-bit/cycle and a 4-bit/cycle instance, 32-bit operands.
module tb_synthesijer_div_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b, a4, b4;
    logic        um, um4, nd, nd4;
    logic        busy, busy4, valid, valid4, dbz, dbz4;
    logic [31:0] q, r, q4, r4;

    int vectors     = 0;
    int miscompares = 0;
    int n;

`ifdef SYNTHESIJER_DIV_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    always #5 clk = ~clk;

    synthesijer_div_multi #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .unsigned_mode(um), .nd(nd),
        .busy(busy), .quantient(q), .remainder(r), .div_by_zero(dbz), .valid(valid)
    );

    synthesijer_div_multi #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset(reset), .a(a4), .b(b4), .unsigned_mode(um4), .nd(nd4),
        .busy(busy4), .quantient(q4), .remainder(r4), .div_by_zero(dbz4), .valid(valid4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; edge E is the next posedge. Returns at the negedge after E.
    task automatic apply1(input logic [31:0] av, input logic [31:0] bv, input logic umv);
        a = av; b = bv; um = umv; nd = 1'b1;
        @(negedge clk);
        nd = 1'b0;
    endtask

    task automatic apply4(input logic [31:0] av, input logic [31:0] bv, input logic umv);
        a4 = av; b4 = bv; um4 = umv; nd4 = 1'b1;
        @(negedge clk);
        nd4 = 1'b0;
    endtask

    // Counts edges until valid is seen; 0 means the cycle budget expired.
    task automatic wait_valid(input bit sel, output int cnt);
        cnt = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (sel ? valid4 : valid) begin
                cnt = i;
                return;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        a = '0; b = '0; um = 1'b0; nd = 1'b0;
        a4 = '0; b4 = '0; um4 = 1'b0; nd4 = 1'b0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_dbz", {31'd0, dbz}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Signed -100 / 7
        @(negedge clk);
        apply1(32'hFFFFFF9C, 32'd7, 1'b0);
        check("s1_busy", {31'd0, busy}, 32'd1);
        wait_valid(1'b0, n);
        check("s1_lat", n, 32'd33);
        check("s1_q", q, 32'hFFFFFFF2);
        check("s1_r", r, 32'hFFFFFFFE);
        check("s1_dbz", {31'd0, dbz}, 32'd0);
        check("s1_busy_low", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("s1_pulse", {31'd0, valid}, 32'd0);
        check("s1_hold_q", q, 32'hFFFFFFF2);

        // Signed overflow: most negative / -1
        apply1(32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_valid(1'b0, n);
        check("ovf_lat", n, 32'd33);
        check("ovf_q", q, 32'h80000000);
        check("ovf_r", r, 32'd0);
        check("ovf_dbz", {31'd0, dbz}, 32'd0);

        // nd during busy is ignored: unsigned 1000/10, stray 77/7 at E+5
        @(negedge clk);
        apply1(32'd1000, 32'd10, 1'b1);
        repeat (4) @(negedge clk);
        apply1(32'd77, 32'd7, 1'b1);
        wait_valid(1'b0, n);
        check("hs_lat", n, 32'd28);
        check("hs_q", q, 32'd100);
        check("hs_r", r, 32'd0);

        // Back-to-back in the valid cycle: signed -5 / 0
        apply1(32'hFFFFFFFB, 32'd0, 1'b0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_valid(1'b0, n);
        check("dz_lat", n, ZERO_LAT);
        check("dz_q", q, 32'hFFFFFFFF);
        check("dz_r", r, 32'hFFFFFFFB);
        check("dz_flag", {31'd0, dbz}, 32'd1);

        // Radix-4 instance: unsigned and signed
        @(negedge clk);
        apply4(32'hFFFFFFF0, 32'h10, 1'b1);
        wait_valid(1'b1, n);
        check("r4u_lat", n, 32'd9);
        check("r4u_q", q4, 32'h0FFFFFFF);
        check("r4u_r", r4, 32'd0);
        @(negedge clk);
        apply4(32'hFFFFFF9C, 32'd7, 1'b0);
        wait_valid(1'b1, n);
        check("r4s_lat", n, 32'd9);
        check("r4s_q", q4, 32'hFFFFFFF2);
        check("r4s_r", r4, 32'hFFFFFFFE);

        // Async reset mid-CALC discards the operation
        @(negedge clk);
        apply1(32'd50, 32'd3, 1'b1);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("ar_q", q, 32'd0);
        check("ar_r", r, 32'd0);
        check("ar_dbz", {31'd0, dbz}, 32'd0);
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_q4", q4, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        apply1(32'd100, 32'hFFFFFFF9, 1'b0);
        wait_valid(1'b0, n);
        check("ar_new_lat", n, 32'd33);
        check("ar_new_q", q, 32'hFFFFFFF2);
        check("ar_new_r", r, 32'd2);
        check("ar_new_dbz", {31'd0, dbz}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
